// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request, response, shared-ALU and counter signals of alu_arbiter
interface alu_arbiter_if #(parameter int DATA_W = 32, parameter int CNT_W = 16);
  logic [1:0] req_valid_i;
  logic [1:0] req_ready_o;
  logic [DATA_W-1:0] req0_src1_i;
  logic [DATA_W-1:0] req0_src2_i;
  logic [DATA_W-1:0] req1_src1_i;
  logic [DATA_W-1:0] req1_src2_i;
  logic [3:0] req0_ctrl_i;
  logic [3:0] req1_ctrl_i;
  logic [DATA_W-1:0] alu_src1_o;
  logic [DATA_W-1:0] alu_src2_o;
  logic [3:0] alu_ctrl_o;
  logic [DATA_W-1:0] alu_result_i;
  logic alu_zero_i;
  logic [1:0] rsp_valid_o;
  logic [1:0] rsp_ready_i;
  logic [DATA_W-1:0] rsp_result_o;
  logic rsp_zero_o;
  logic rsp_err_o;
  logic [CNT_W-1:0] ops_cnt_o;
  modport slave (
    input req_valid_i, req0_src1_i, req0_src2_i, req1_src1_i, req1_src2_i, req0_ctrl_i, req1_ctrl_i,
    input alu_result_i, alu_zero_i, rsp_ready_i,
    output req_ready_o, alu_src1_o, alu_src2_o, alu_ctrl_o, rsp_valid_o, rsp_result_o, rsp_zero_o, rsp_err_o, ops_cnt_o
  );
  modport master (
    output req_valid_i, req0_src1_i, req0_src2_i, req1_src1_i, req1_src2_i, req0_ctrl_i, req1_ctrl_i,
    output alu_result_i, alu_zero_i, rsp_ready_i,
    input req_ready_o, alu_src1_o, alu_src2_o, alu_ctrl_o, rsp_valid_o, rsp_result_o, rsp_zero_o, rsp_err_o, ops_cnt_o
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters (IDLE/EXEC/RESP); define ALU_ARBITER_RR_EN for round-robin, else fixed priority
module alu_arbiter #(
  parameter int DATA_W = 32,
  parameter int CNT_W = 16
) (
  input logic clk_i,
  input logic rst_i,
  alu_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state_q, state_d;
  logic owner_q, owner_d;
  logic [DATA_W-1:0] src1_q, src1_d, src2_q, src2_d, result_q, result_d;
  logic [3:0] ctrl_q, ctrl_d;
  logic zero_q, zero_d, err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic g, legal, accept, rsp_hs;
`ifdef ALU_ARBITER_RR_EN
  logic last_q, last_d;
  always_comb g = &bus.req_valid_i ? ~last_q : ~bus.req_valid_i[0];
  always_comb last_d = accept ? g : last_q;
  always_ff @(posedge clk_i) last_q <= rst_i ? 1'b1 : last_d;
`else
  always_comb g = ~bus.req_valid_i[0];
`endif
  always_comb begin
    bus.req_ready_o = (state_q == IDLE && !rst_i && bus.req_valid_i[g]) ? (g ? 2'b10 : 2'b01) : 2'b00;
    accept = |bus.req_ready_o;
    legal = ctrl_q inside {4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b1100, 4'b0111};
    rsp_hs = state_q == RESP && bus.rsp_ready_i[owner_q];
    state_d = state_q == IDLE ? (accept ? EXEC : IDLE) : state_q == EXEC ? RESP : (rsp_hs ? IDLE : RESP);
    owner_d = accept ? g : owner_q;
    src1_d = accept ? (g ? bus.req1_src1_i : bus.req0_src1_i) : src1_q;
    src2_d = accept ? (g ? bus.req1_src2_i : bus.req0_src2_i) : src2_q;
    ctrl_d = accept ? (g ? bus.req1_ctrl_i : bus.req0_ctrl_i) : ctrl_q;
    result_d = state_q == EXEC ? (legal ? bus.alu_result_i : '0) : result_q;
    zero_d = state_q == EXEC ? (legal ? bus.alu_zero_i : 1'b1) : zero_q;
    err_d = state_q == EXEC ? ~legal : err_q;
    cnt_d = rsp_hs ? cnt_q + CNT_W'(1) : cnt_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      src1_q <= '0;
      src2_q <= '0;
      ctrl_q <= '0;
      result_q <= '0;
      zero_q <= 1'b0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      src1_q <= src1_d;
      src2_q <= src2_d;
      ctrl_q <= ctrl_d;
      result_q <= result_d;
      zero_q <= zero_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end
  always_comb begin
    bus.alu_src1_o = state_q == EXEC ? src1_q : '0;
    bus.alu_src2_o = state_q == EXEC ? src2_q : '0;
    bus.alu_ctrl_o = state_q == EXEC ? ctrl_q : 4'b0000;
    bus.rsp_valid_o = state_q == RESP ? {owner_q, ~owner_q} : 2'b00;
    bus.rsp_result_o = result_q;
    bus.rsp_zero_o = zero_q;
    bus.rsp_err_o = err_q;
    bus.ops_cnt_o = cnt_q;
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: table-driven scoreboard bench for alu_arbiter with a behavioural shared ALU
module tb_alu_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  logic [3:0] exp_cnt = 4'd0;
`ifdef ALU_ARBITER_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  typedef struct packed {
    logic r;
    logic [3:0] ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic z;
    logic e;
    logic [2:0] hold;
  } vec_t;
  typedef struct packed {
    logic r;
    logic [31:0] res;
    logic z;
    logic e;
  } exp_t;
  exp_t sbq[$];
  vec_t vt[9];
  alu_arbiter_if #(.DATA_W(32), .CNT_W(4)) bus();
  alu_arbiter #(.DATA_W(32), .CNT_W(4)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  always #5 clk = ~clk;
  always_comb begin
    case (bus.alu_ctrl_o)
      4'b0000: bus.alu_result_i = bus.alu_src1_o & bus.alu_src2_o;
      4'b0001: bus.alu_result_i = bus.alu_src1_o | bus.alu_src2_o;
      4'b0010: bus.alu_result_i = bus.alu_src1_o + bus.alu_src2_o;
      4'b0110: bus.alu_result_i = bus.alu_src1_o - bus.alu_src2_o;
      4'b1100: bus.alu_result_i = ~(bus.alu_src1_o | bus.alu_src2_o);
      4'b0111: bus.alu_result_i = {31'd0, $signed(bus.alu_src1_o) < $signed(bus.alu_src2_o)};
      default: bus.alu_result_i = 32'hDEADBEEF;
    endcase
    bus.alu_zero_i = bus.alu_result_i == 32'd0;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic pop_cmp(input string name);
    exp_t x;
    n_chk++;
    if (sbq.size() == 0) begin
      n_fail++;
      $display("FAIL %s_sb_empty: got 0 entries expected 1", name);
    end else begin
      x = sbq.pop_front();
      chk({name, "_owner"}, bus.rsp_valid_o, x.r ? 2'b10 : 2'b01);
      chk({name, "_result"}, bus.rsp_result_o, x.res);
      chk({name, "_zero"}, bus.rsp_zero_o, x.z);
      chk({name, "_err"}, bus.rsp_err_o, x.e);
    end
  endtask
  task automatic set_req(input logic r, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    if (r) begin
      bus.req1_ctrl_i = c;
      bus.req1_src1_i = a;
      bus.req1_src2_i = b;
    end else begin
      bus.req0_ctrl_i = c;
      bus.req0_src1_i = a;
      bus.req0_src2_i = b;
    end
  endtask
  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    bus.req_valid_i = 2'b00;
    bus.rsp_ready_i = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    sbq.delete();
    exp_cnt = 4'd0;
  endtask
  task automatic run_op(input vec_t v);
    logic [1:0] oh;
    oh = v.r ? 2'b10 : 2'b01;
    @(negedge clk);
    set_req(v.r, v.ctrl, v.a, v.b);
    bus.req_valid_i = oh;
    #1 chk("ready", bus.req_ready_o, oh);
    sbq.push_back('{v.r, v.res, v.z, v.e});
    @(negedge clk);
    bus.req_valid_i = 2'b00;
    #1 chk("exec_ctrl", bus.alu_ctrl_o, v.ctrl);
    chk("exec_src1", bus.alu_src1_o, v.a);
    chk("exec_rsp", bus.rsp_valid_o, 2'b00);
    chk("exec_ready", bus.req_ready_o, 2'b00);
    @(negedge clk);
    bus.rsp_ready_i = ~oh;
    bus.req_valid_i = ~oh;
    #1 chk("resp_alu", bus.alu_src1_o, 32'd0);
    for (int h = 0; h < int'(v.hold); h++) begin
      chk("hold_valid", bus.rsp_valid_o, oh);
      chk("hold_result", bus.rsp_result_o, v.res);
      chk("hold_zero", bus.rsp_zero_o, v.z);
      chk("hold_ready", bus.req_ready_o, 2'b00);
      @(negedge clk);
      #1;
    end
    bus.rsp_ready_i = oh;
    bus.req_valid_i = 2'b00;
    #1 pop_cmp("rsp");
    @(posedge clk);
    exp_cnt++;
    @(negedge clk);
    bus.rsp_ready_i = 2'b00;
    #1 chk("cnt", bus.ops_cnt_o, exp_cnt);
    chk("idle_rsp", bus.rsp_valid_o, 2'b00);
  endtask
  initial begin
    vt[0] = '{1'b0, 4'b0010, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0, 3'd0};
    vt[1] = '{1'b1, 4'b0110, 32'd3, 32'd3, 32'd0, 1'b1, 1'b0, 3'd4};
    vt[2] = '{1'b0, 4'b1111, 32'd5, 32'd7, 32'd0, 1'b1, 1'b1, 3'd1};
    vt[3] = '{1'b1, 4'b0000, 32'hF0, 32'h3C, 32'h30, 1'b0, 1'b0, 3'd0};
    vt[4] = '{1'b0, 4'b0001, 32'hF0, 32'h0F, 32'hFF, 1'b0, 1'b0, 3'd2};
    vt[5] = '{1'b1, 4'b1100, 32'd0, 32'd0, 32'hFFFFFFFF, 1'b0, 1'b0, 3'd0};
    vt[6] = '{1'b0, 4'b0111, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0, 1'b0, 3'd0};
    vt[7] = '{1'b1, 4'b0111, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b1, 1'b0, 3'd1};
    vt[8] = '{1'b1, 4'b0011, 32'd1, 32'd1, 32'd0, 1'b1, 1'b1, 3'd0};
    bus.req_valid_i = 2'b01;
    bus.rsp_ready_i = 2'b00;
    set_req(1'b0, 4'b0010, 32'd1, 32'd1);
    set_req(1'b1, 4'b0010, 32'd2, 32'd2);
    @(negedge clk);
    #1 chk("rst_ready", bus.req_ready_o, 2'b00);
    chk("rst_rsp_valid", bus.rsp_valid_o, 2'b00);
    chk("rst_result", bus.rsp_result_o, 32'd0);
    chk("rst_zero", bus.rsp_zero_o, 1'b0);
    chk("rst_err", bus.rsp_err_o, 1'b0);
    chk("rst_cnt", bus.ops_cnt_o, 4'd0);
    chk("rst_alu", bus.alu_src1_o, 32'd0);
    bus.req_valid_i = 2'b00;
    rst = 1'b0;
    foreach (vt[i]) run_op(vt[i]);
    reset_dut();
    set_req(1'b0, 4'b0010, 32'd1, 32'd1);
    set_req(1'b1, 4'b0010, 32'd2, 32'd2);
    bus.req_valid_i = 2'b11;
    bus.rsp_ready_i = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1 chk("grant", bus.req_ready_o, (RR && k[0]) ? 2'b10 : 2'b01);
      sbq.push_back((RR && k[0]) ? '{1'b1, 32'd4, 1'b0, 1'b0} : '{1'b0, 32'd2, 1'b0, 1'b0});
      @(negedge clk);
      @(negedge clk);
      #1 pop_cmp("arb");
      @(negedge clk);
    end
    bus.req_valid_i = 2'b00;
    bus.rsp_ready_i = 2'b00;
    #1 chk("arb_cnt", bus.ops_cnt_o, 4'd4);
    reset_dut();
    set_req(1'b1, 4'b0110, 32'd9, 32'd4);
    bus.req_valid_i = 2'b10;
    @(negedge clk);
    bus.req_valid_i = 2'b00;
    @(negedge clk);
    #1 chk("mid_rsp_valid", bus.rsp_valid_o, 2'b10);
    chk("mid_rsp_result", bus.rsp_result_o, 32'd5);
    rst = 1'b1;
    bus.rsp_ready_i = 2'b10;
    @(negedge clk);
    rst = 1'b0;
    bus.rsp_ready_i = 2'b00;
    bus.req_valid_i = 2'b11;
    #1 chk("mid_rst_valid", bus.rsp_valid_o, 2'b00);
    chk("mid_rst_cnt", bus.ops_cnt_o, 4'd0);
    chk("mid_rst_result", bus.rsp_result_o, 32'd0);
    chk("mid_rst_err", bus.rsp_err_o, 1'b0);
    chk("mid_rst_grant", bus.req_ready_o, 2'b01);
    bus.req_valid_i = 2'b00;
    reset_dut();
    for (int i = 0; i < 16; i++) run_op('{1'b0, 4'b0010, 32'(i), 32'd1, 32'(i + 1), 1'b0, 1'b0, 3'd0});
    chk("wrap", bus.ops_cnt_o, 4'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/result width.
REQ-002 SHALL have parameter CNT_W, default 16, completed-operation counter width.
REQ-003 SHALL have port clk_i  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_valid_i  input  2  per-requester request valid, bit k = requester k.
REQ-006 SHALL have port req_ready_o  output  2  per-requester accept; at most one bit high.
REQ-007 SHALL have ports req0_src1_i, req0_src2_i, req1_src1_i, req1_src2_i  input  DATA_W  operands of requester 0/1.
REQ-008 SHALL have ports req0_ctrl_i, req1_ctrl_i  input  4  ALU op code of requester 0/1.
REQ-009 SHALL have ports alu_src1_o, alu_src2_o  output  DATA_W, and alu_ctrl_o  output  4  drive to shared ALU.
REQ-010 SHALL have ports alu_result_i  input  DATA_W, and alu_zero_i  input  1  return from shared ALU (combinational ALU).
REQ-011 SHALL have port rsp_valid_o  output  2  one-hot response valid to owning requester.
REQ-012 SHALL have port rsp_ready_i  input  2  per-requester response accept.
REQ-013 SHALL have ports rsp_result_o  output  DATA_W, rsp_zero_o  output  1, rsp_err_o  output  1  response payload.
REQ-014 SHALL have port ops_cnt_o  output  CNT_W  count of completed response handshakes.

Function
REQ-015 SHALL implement FSM IDLE, EXEC, RESP.
REQ-016 IDLE: SHALL compute grant g from req_valid_i and drive req_ready_o[g]=1 only when req_valid_i[g]=1; all other ready bits 0.
REQ-017 IDLE->EXEC on req_valid_i[g] & req_ready_o[g]; SHALL register src1, src2, ctrl of requester g and owner id g.
REQ-018 EXEC: SHALL drive alu_*_o from registered operands; capture alu_result_i, alu_zero_i into response registers; EXEC->RESP after exactly one cycle.
REQ-019 alu_*_o SHALL be 0 in IDLE and RESP.
REQ-020 Legal ctrl codes: 0000 and, 0001 or, 0010 add, 0110 sub, 1100 nor, 0111 slt; any other code SHALL yield rsp_err_o=1, rsp_result_o=0, rsp_zero_o=1 (ALU output ignored); legal codes yield rsp_err_o=0.
REQ-021 RESP: rsp_valid_o[owner]=1, payload stable until rsp_ready_i[owner]=1; RESP->IDLE on that cycle; rsp_ready_i of non-owner SHALL be ignored.
REQ-022 Latency: accept at cycle N -> rsp_valid_o high at N+2; minimum 3 cycles per operation; no request accepted in EXEC or RESP (req_ready_o=0).
REQ-023 Request changes while not ready SHALL have no effect; deassertion of req_valid_i before acceptance SHALL drop that request silently.
REQ-024 ops_cnt_o SHALL increment by 1 on each response handshake, wrapping all-ones -> 0 modulo 2^CNT_W; errored ops count too.
REQ-025 Arbitration with single valid requester SHALL grant it regardless of policy.

Reset
REQ-026 On rst_i=1 at clock edge: state=IDLE, req_ready_o=0 that cycle, rsp_valid_o=0, rsp_result_o=0, rsp_zero_o=0, rsp_err_o=0, alu_*_o=0, ops_cnt_o=0, last-served pointer=1.
REQ-027 Reset mid-operation (EXEC or RESP) SHALL discard the in-flight op with no response and no count increment.
REQ-028 rst_i SHALL override every simultaneous event, including a pending handshake.

Configuration
REQ-029 Macro ALU_ARBITER_RR_EN defined: SHALL use round-robin; when both valid, grant requester != last-served; last-served updated on acceptance.
REQ-030 ALU_ARBITER_RR_EN undefined: SHALL use fixed priority, requester 0 always wins when both valid; pointer unused.

Verification
REQ-031 Req0 add 5+7 alone -> accepted cycle N, rsp_valid_o=01 at N+2, result 12, zero 0, err 0, ops_cnt_o 0->1.
REQ-032 Req1 sub 3-3 with rsp_ready_i held 0 for 4 cycles -> rsp_valid_o=10 held, result 0, zero 1, payload stable, req_ready_o=00 throughout.
REQ-033 Both valid continuously, RR_EN defined -> grant order 0,1,0,1; RR_EN undefined -> 0,0,0,0.
REQ-034 Req0 ctrl 1111 -> rsp_err_o 1, result 0, zero 1, counter increments.
REQ-035 rst_i pulsed during RESP of op from req1 -> rsp_valid_o 00 next cycle, ops_cnt_o 0, next grant requester 0.
REQ-036 CNT_W=4, 16 completed ops from 0 -> ops_cnt_o wraps to 0; slt -1<1 -> result 1.
